// File: rtl/hdmi_line_fetch_ctrl.sv
// Frame-buffer line fetcher: turns line requests into back-to-back Avalon-MM bursts
// and streams the returned words to the HDMI line FIFO as one Avalon-ST packet per line.
module hdmi_line_fetch_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    H_ACTIVE   = 1280,
  parameter int                    V_ACTIVE   = 720,
  parameter int                    BURST_LEN  = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR0 = 32'h0000_0000,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR1 = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_buffer_ready,
  input  logic                  frame_done_i,
  input  logic                  line_request_i,
  output logic [ADDR_WIDTH-1:0] avm_address_o,
  output logic                  avm_read_o,
  output logic [7:0]            avm_burstcount_o,
  input  logic                  avm_waitrequest_i,
  input  logic [DATA_WIDTH-1:0] avm_readdata_i,
  input  logic                  avm_readdatavalid_i,
  output logic                  aso_src_valid_o,
  output logic [DATA_WIDTH-1:0] aso_src_data_o,
  output logic                  aso_src_startofpacket_o,
  output logic                  aso_src_endofpacket_o,
  output logic [9:0]            line_cnt_o,
  output logic                  busy_o,
  output logic                  overrun_o
);

  localparam int WCW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_BYTES  = ADDR_WIDTH'(H_ACTIVE * 4);
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * 4);
  localparam logic [WCW-1:0]        LAST_WORD   = WCW'(H_ACTIVE - 1);
  localparam logic [BCW-1:0]        LAST_BEAT   = BCW'(BURST_LEN - 1);
  localparam logic [9:0]            LAST_LINE   = 10'(V_ACTIVE - 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

  state_e                state_q, state_d;
  logic [9:0]            line_cnt_q, line_cnt_d;
  logic [ADDR_WIDTH-1:0] line_off_q, line_off_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  newest_bank_q, newest_bank_d;
  logic                  read_bank_q, read_bank_d;
  logic [WCW-1:0]        word_cnt_q, word_cnt_d;
  logic [BCW-1:0]        beat_cnt_q, beat_cnt_d;
  logic                  overrun_q, overrun_d;
  logic                  valid_q, sop_q, eop_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  beat;
  logic                  sel_bank;

  always_comb begin
    state_d       = state_q;
    line_cnt_d    = line_cnt_q;
    line_off_d    = line_off_q;
    addr_d        = addr_q;
    newest_bank_d = newest_bank_q ^ frame_done_i;
    read_bank_d   = read_bank_q;
    word_cnt_d    = word_cnt_q;
    beat_cnt_d    = beat_cnt_q;
    overrun_d     = overrun_q;
    beat          = 1'b0;
    // A new frame starts on line 0, so that is where the freshest bank is picked up.
    sel_bank      = (line_cnt_q == '0) ? newest_bank_d : read_bank_q;

    case (state_q)
      IDLE: begin
        if (!frame_buffer_ready) begin
          line_cnt_d = '0;
          line_off_d = '0;
        end else if (line_request_i) begin
          state_d     = CMD;
          read_bank_d = sel_bank;
          addr_d      = (sel_bank ? BASE_ADDR1 : BASE_ADDR0) + line_off_q;
          word_cnt_d  = '0;
          beat_cnt_d  = '0;
        end
      end
      CMD: begin
        if (!avm_waitrequest_i) state_d = DATA;
      end
      DATA: begin
        if (avm_readdatavalid_i) begin
          beat       = 1'b1;
          word_cnt_d = word_cnt_q + 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            if (word_cnt_q == LAST_WORD) begin
              state_d = IDLE;
              if (!frame_buffer_ready || line_cnt_q == LAST_LINE) begin
                line_cnt_d = '0;
                line_off_d = '0;
              end else begin
                line_cnt_d = line_cnt_q + 1'b1;
                line_off_d = line_off_q + LINE_BYTES;
              end
            end else begin
              state_d = CMD;
              addr_d  = addr_q + BURST_BYTES;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (line_request_i && state_q != IDLE) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      line_cnt_q    <= '0;
      line_off_q    <= '0;
      addr_q        <= '0;
      newest_bank_q <= 1'b0;
      read_bank_q   <= 1'b0;
      word_cnt_q    <= '0;
      beat_cnt_q    <= '0;
      overrun_q     <= 1'b0;
      valid_q       <= 1'b0;
      sop_q         <= 1'b0;
      eop_q         <= 1'b0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      line_cnt_q    <= line_cnt_d;
      line_off_q    <= line_off_d;
      addr_q        <= addr_d;
      newest_bank_q <= newest_bank_d;
      read_bank_q   <= read_bank_d;
      word_cnt_q    <= word_cnt_d;
      beat_cnt_q    <= beat_cnt_d;
      overrun_q     <= overrun_d;
      valid_q       <= beat;
      sop_q         <= beat && (word_cnt_q == '0);
      eop_q         <= beat && (word_cnt_q == LAST_WORD);
      if (beat) data_q <= avm_readdata_i;
    end
  end

  assign avm_address_o           = addr_q;
  assign avm_read_o              = (state_q == CMD);
  assign avm_burstcount_o        = 8'(BURST_LEN);
  assign aso_src_valid_o         = valid_q;
  assign aso_src_data_o          = data_q;
  assign aso_src_startofpacket_o = sop_q;
  assign aso_src_endofpacket_o   = eop_q;
  assign line_cnt_o              = line_cnt_q;
  assign busy_o                  = (state_q != IDLE);
  assign overrun_o               = overrun_q;

endmodule

// File: tb/tb_hdmi_line_fetch_ctrl.sv
// Directed bench for hdmi_line_fetch_ctrl with a small burst-read slave and a packet monitor.
// Runs with 128-word lines in 64-word bursts and an 8-line frame so whole frames stay short.
module tb_hdmi_line_fetch_ctrl;

  localparam int H  = 128;
  localparam int V  = 8;
  localparam int BL = 64;

  logic        clk = 1'b0;
  logic        reset, ready, frameDone, lineReq;
  logic [31:0] avmAddr;
  logic        avmRead;
  logic [7:0]  burstCount;
  logic        waitReq;
  logic [31:0] rdata = '0;
  logic        rdv = 1'b0;
  logic        asoValid, asoSop, asoEop;
  logic [31:0] asoData;
  logic [9:0]  lineCnt;
  logic        busy, overrun;

  int checks = 0;
  int errors = 0;
  int cmdBase = 0;

  hdmi_line_fetch_ctrl #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .BURST_LEN(BL)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .frame_buffer_ready     (ready),
    .frame_done_i           (frameDone),
    .line_request_i         (lineReq),
    .avm_address_o          (avmAddr),
    .avm_read_o             (avmRead),
    .avm_burstcount_o       (burstCount),
    .avm_waitrequest_i      (waitReq),
    .avm_readdata_i         (rdata),
    .avm_readdatavalid_i    (rdv),
    .aso_src_valid_o        (asoValid),
    .aso_src_data_o         (asoData),
    .aso_src_startofpacket_o(asoSop),
    .aso_src_endofpacket_o  (asoEop),
    .line_cnt_o             (lineCnt),
    .busy_o                 (busy),
    .overrun_o              (overrun)
  );

  always #5 clk = ~clk;

  // Burst slave: stalls each command for stallCycles, then returns BL words valued addr/4 + i.
  int          stallCycles = 0;
  int          stallCnt = 0;
  int          beatsLeft = 0;
  int          cmdCount = 0;
  logic [31:0] nextData = '0;
  logic [31:0] lastCmdAddr = '0;

  assign waitReq = (stallCnt < stallCycles);

  always @(posedge clk) begin
    rdv <= 1'b0;
    if (beatsLeft != 0) begin
      rdv       <= 1'b1;
      rdata     <= nextData;
      nextData  <= nextData + 1;
      beatsLeft <= beatsLeft - 1;
    end
    if (avmRead) begin
      if (waitReq) stallCnt <= stallCnt + 1;
      else begin
        stallCnt    <= 0;
        beatsLeft   <= BL;
        nextData    <= avmAddr >> 2;
        cmdCount    <= cmdCount + 1;
        lastCmdAddr <= avmAddr;
      end
    end
  end

  // Packet monitor: counts words and markers, and checks each output word follows its beat by one cycle.
  int          words = 0, sopCount = 0, eopCount = 0, sopAt = -1, eopAt = -1;
  int          orderErrs = 0, latErrs = 0;
  logic [31:0] firstData = '0, lastData = '0, prevData = '0;
  logic        prevRdv = 1'b0;
  logic        monClear = 1'b0;

  always @(posedge clk) begin
    prevRdv  <= rdv;
    prevData <= rdata;
    if (monClear) begin
      words    <= 0;
      sopCount <= 0;
      eopCount <= 0;
      sopAt    <= -1;
      eopAt    <= -1;
    end else if (asoValid) begin
      if (words == 0) firstData <= asoData;
      lastData <= asoData;
      words    <= words + 1;
      if (asoSop) begin
        sopCount <= sopCount + 1;
        sopAt    <= words;
      end
      if (asoEop) begin
        eopCount <= eopCount + 1;
        eopAt    <= words;
      end
      if (!prevRdv) latErrs <= latErrs + 1;
      if (asoData !== prevData) orderErrs <= orderErrs + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic fd);
    lineReq   = req;
    frameDone = fd;
    @(negedge clk);
    lineReq   = 1'b0;
    frameDone = 1'b0;
  endtask

  task automatic clearMonitor();
    monClear = 1'b1;
    @(negedge clk);
    monClear = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    checkOutput({tag, "_idle"}, busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic runLine(input string tag, input logic [31:0] expAddr,
                         input logic fdAtReq, input logic fdMid, input logic dropReady);
    clearMonitor();
    applyStimulus(1'b1, fdAtReq);
    checkOutput({tag, "_read"}, avmRead, 1'b1);
    checkOutput({tag, "_addr"}, avmAddr, expAddr);
    repeat (20) @(negedge clk);
    if (fdMid) applyStimulus(1'b0, 1'b1);
    if (dropReady) ready = 1'b0;
    waitIdle(tag);
    checkOutput({tag, "_words"}, words, H);
    checkOutput({tag, "_first"}, firstData, expAddr >> 2);
    checkOutput({tag, "_last"}, lastData, (expAddr >> 2) + 127);
  endtask

  initial begin
    reset     = 1'b1;
    ready     = 1'b1;
    lineReq   = 1'b0;
    frameDone = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("rst_read", avmRead, 1'b0);
    checkOutput("rst_addr", avmAddr, 32'h0);
    checkOutput("rst_burstcount", burstCount, 8'd64);
    checkOutput("rst_valid", asoValid, 1'b0);
    checkOutput("rst_sop", asoSop, 1'b0);
    checkOutput("rst_eop", asoEop, 1'b0);
    checkOutput("rst_linecnt", lineCnt, 10'd0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_overrun", overrun, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // T2: single line, two bursts at 0x0 and 0x100
    clearMonitor();
    cmdBase = cmdCount;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t2_read", avmRead, 1'b1);
    checkOutput("t2_addr", avmAddr, 32'h0);
    checkOutput("t2_busy", busy, 1'b1);
    waitIdle("t2");
    checkOutput("t2_words", words, 128);
    checkOutput("t2_sopcount", sopCount, 1);
    checkOutput("t2_sopat", sopAt, 0);
    checkOutput("t2_eopcount", eopCount, 1);
    checkOutput("t2_eopat", eopAt, 127);
    checkOutput("t2_first", firstData, 32'd0);
    checkOutput("t2_last", lastData, 32'd127);
    checkOutput("t2_cmds", cmdCount - cmdBase, 2);
    checkOutput("t2_addr2", lastCmdAddr, 32'h100);
    checkOutput("t2_linecnt", lineCnt, 10'd1);

    // T3: five stall cycles per command, line 1 at 0x200
    stallCycles = 5;
    clearMonitor();
    cmdBase = cmdCount;
    applyStimulus(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("t3_read_held", avmRead, 1'b1);
      checkOutput("t3_addr_held", avmAddr, 32'h200);
      @(negedge clk);
    end
    checkOutput("t3_read_drop", avmRead, 1'b0);
    checkOutput("t3_one_cmd", cmdCount - cmdBase, 1);
    waitIdle("t3");
    checkOutput("t3_words", words, 128);
    checkOutput("t3_cmds", cmdCount - cmdBase, 2);
    checkOutput("t3_addr2", lastCmdAddr, 32'h300);
    checkOutput("t3_linecnt", lineCnt, 10'd2);
    stallCycles = 0;

    // T5: second request three cycles after the first is dropped and flagged
    clearMonitor();
    cmdBase = cmdCount;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_addr", avmAddr, 32'h400);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0);
    checkOutput("t5_overrun", overrun, 1'b1);
    checkOutput("t5_busy", busy, 1'b1);
    waitIdle("t5");
    checkOutput("t5_words", words, 128);
    checkOutput("t5_eopcount", eopCount, 1);
    checkOutput("t5_linecnt", lineCnt, 10'd3);
    repeat (10) @(negedge clk);
    checkOutput("t5_no_refetch", cmdCount - cmdBase, 2);
    checkOutput("t5_sticky", overrun, 1'b1);

    // T4: frame_done during line 3; remaining lines stay on bank 0
    for (int l = 3; l < V; l++) runLine("t4_bank0", 32'h200 * l, 1'b0, (l == 3), 1'b0);
    checkOutput("t4_wrap", lineCnt, 10'd0);
    runLine("t4_newframe", 32'h0040_0000, 1'b0, 1'b0, 1'b0);
    runLine("t4_midframe_fd", 32'h0040_0200, 1'b0, 1'b1, 1'b0);
    for (int l = 2; l < V; l++) runLine("t4_bank1_hold", 32'h0040_0000 + 32'h200 * l, 1'b0, 1'b0, 1'b0);
    checkOutput("t6_wrap", lineCnt, 10'd0);

    // frame_done together with a line-0 acceptance selects the toggled bank
    runLine("fd_same_cycle", 32'h0040_0000, 1'b1, 1'b0, 1'b0);
    checkOutput("fd_same_linecnt", lineCnt, 10'd1);

    // ready falling mid-line: line completes, then line count restarts
    runLine("ready_fall", 32'h0040_0200, 1'b0, 1'b0, 1'b1);
    checkOutput("ready_fall_linecnt", lineCnt, 10'd0);
    ready = 1'b1;
    @(negedge clk);
    runLine("line0_again", 32'h0040_0000, 1'b0, 1'b0, 1'b0);
    checkOutput("line0_again_cnt", lineCnt, 10'd1);

    // T6: request while not ready is ignored and forces line count to 0
    ready = 1'b0;
    cmdBase = cmdCount;
    applyStimulus(1'b1, 1'b0);
    checkOutput("t6_nr_read", avmRead, 1'b0);
    checkOutput("t6_nr_busy", busy, 1'b0);
    checkOutput("t6_nr_linecnt", lineCnt, 10'd0);
    repeat (3) @(negedge clk);
    checkOutput("t6_nr_cmds", cmdCount - cmdBase, 0);
    ready = 1'b1;
    @(negedge clk);

    // T1: reset around beat 10 of a line
    clearMonitor();
    applyStimulus(1'b1, 1'b0);
    checkOutput("t1_addr", avmAddr, 32'h0040_0000);
    for (int i = 0; i < 300 && words < 10; i++) @(negedge clk);
    checkOutput("t1_reached_beat10", (words >= 10), 1'b1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t1_read", avmRead, 1'b0);
    checkOutput("t1_addr0", avmAddr, 32'h0);
    checkOutput("t1_valid", asoValid, 1'b0);
    checkOutput("t1_data", asoData, 32'h0);
    checkOutput("t1_busy", busy, 1'b0);
    checkOutput("t1_linecnt", lineCnt, 10'd0);
    checkOutput("t1_overrun", overrun, 1'b0);
    reset = 1'b0;
    clearMonitor();
    repeat (100) @(negedge clk);
    checkOutput("t1_dropped_beats", words, 0);
    checkOutput("t1_no_cmd", avmRead, 1'b0);
    runLine("t1_after", 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_after_linecnt", lineCnt, 10'd1);

    checkOutput("stream_latency", latErrs, 0);
    checkOutput("stream_data", orderErrs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
